// File: rtl/serial_parallel.sv
// rtl/serial_parallel.sv - MSB-first serial-to-byte deserialiser with comma alignment and lock
// Optional feature macro: SERIAL_PARALLEL_IDLE_CNT_EN adds the saturating idle_cnt output.
module serial_parallel #(
  parameter logic [7:0] IDLE_CHAR  = 8'hBC,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
`ifdef SERIAL_PARALLEL_IDLE_CNT_EN
  ,
  output logic [7:0] idle_cnt
`endif
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // bc_cnt value on which the next aligned idle completes lock
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);

  state_t     state;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt;
  logic [3:0] bc_cnt;

  logic [7:0] next_byte;
  logic       is_idle;
  logic       byte_done;

  // The byte formed by the bit arriving on this edge plus the seven before it
  assign next_byte = {shift_q[6:0], data_in};
  assign is_idle   = (next_byte == IDLE_CHAR);
  assign byte_done = (bit_cnt == 3'd7);

  // Free-running history of the last eight received bits
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      shift_q <= 8'h00;
    end else begin
      shift_q <= next_byte;
    end
  end

  // Alignment FSM: slide bit by bit until a comma, confirm on byte boundaries, then deliver data
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      bit_cnt   <= 3'd0;
      bc_cnt    <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      bit_cnt   <= bit_cnt + 3'd1;
      case (state)
        SEARCH: begin
          // The comma just seen ends a byte, so the next bit is a byte MSB
          if (is_idle) begin
            state   <= ALIGN;
            bit_cnt <= 3'd0;
            bc_cnt  <= 4'd1;
          end
        end
        ALIGN: begin
          if (byte_done) begin
            if (is_idle) begin
              bc_cnt <= bc_cnt + 4'd1;
              if (bc_cnt == LOCK_LAST) begin
                state  <= LOCKED;
                active <= 1'b1;
              end
            end else begin
              // Misaligned guess: resume sliding from the following bit
              state  <= SEARCH;
              bc_cnt <= 4'd0;
            end
          end
        end
        LOCKED: begin
          // Idle bytes are absorbed; only payload bytes are published
          if (byte_done && !is_idle) begin
            data_out  <= next_byte;
            valid_out <= 1'b1;
          end
        end
        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

`ifdef SERIAL_PARALLEL_IDLE_CNT_EN
  // Count idle bytes received after lock, saturating so the count never wraps
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      idle_cnt <= 8'h00;
    end else if (state == LOCKED && byte_done && is_idle && idle_cnt != 8'hFF) begin
      idle_cnt <= idle_cnt + 8'h01;
    end
  end
`endif

endmodule
